mac_frame_generator: RTL and testbench
======================================

Name: mac_frame_generator

Overview:
Replay transmitter for the sniffer datapath. It produces a 32-bit word stream containing a 48-bit MAC address embedded at a programmable byte offset, followed by a counting payload. The stream feeds the MAC comparator stage on-chip so MAC matching can be exercised at all four byte alignments without live Ethernet traffic. Frame parameters are programmed from the Atom and start on a single pulse.

Parameters:
PAYLOAD_W, 9, width of payload word count (maximum 511 words)
FILL_BYTE, 8'h00, value of pad bytes in header words

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
clear  input  1  synchronous abort; returns block to IDLE
start  input  1  one-cycle request to emit a frame; honoured only in IDLE
mac_in  input  48  MAC to embed; mac_in[47:40] is the first byte on the wire
byte_offset  input  2  number of pad bytes preceding the MAC (0..3)
payload_words  input  PAYLOAD_W  payload length in words (0 allowed)
seed  input  32  first payload word value
ready  input  1  downstream accepts data_out this cycle
data_out  output  32  frame word; byte k of the word sits at [31-8k -: 8]
data_valid  output  1  data_out holds a valid word
last  output  1  qualifies the final word of the frame
busy  output  1  high from the cycle after an accepted start until the final handshake
done  output  1  one-cycle pulse in the cycle after the final handshake

Behaviour:
- Reset (rst=1, async): state IDLE. data_out=0, data_valid=0, last=0, busy=0, done=0. All captured registers are zeroed.
- Capture: start in IDLE latches mac_in, byte_offset, payload_words and seed. Input changes while busy are ignored. start while busy is ignored with no queueing.
- Latency: start at cycle N gives data_valid=1 with the first header word at N+1.
- Byte stream: FILL_BYTE × byte_offset, then the 6 MAC bytes (MSB first), then FILL_BYTE padding to a word boundary. This yields 2 header words for offsets 0–2 and 3 header words for offset 3.
- Payload: word i = seed + i, modulo 2^32 (wraps).
- Handshake: a word transfers when data_valid & ready. While data_valid & !ready, data_out, last and data_valid hold stable. The block never deasserts valid without a transfer.
- last: asserted on the final payload word. If payload_words=0, it is asserted on the final header word instead.
- FSM states: IDLE, HDR, PAY, DONE.
  - IDLE → HDR on start.
  - HDR → PAY after the last header word transfers, if payload_words≠0.
  - HDR → DONE after the last header word transfers, if payload_words=0.
  - PAY → DONE after the last payload word transfers.
  - DONE → IDLE unconditionally; done=1 for this single cycle. A start arriving in DONE is ignored.
- Counters: hdr_idx (2 bits) and pay_cnt (PAYLOAD_W bits). Both advance only on transfer.
- clear (sync, priority below rst, above everything else): next state IDLE, data_valid=0, last=0, busy=0, no done pulse. clear together with start gives IDLE; start is dropped.
- Reset asserted mid-frame aborts immediately. No done pulse is produced.

Decomposition:
- Package mac_gen_pkg: state enum gen_state_t {IDLE,HDR,PAY,DONE}, HDR_WORDS_MAX=3, byte-lane helper constants.
- Sub-module mac_header_packer (combinational): {mac, byte_offset} → three header words plus hdr_count (2 or 3).

Test Plan:
- offset=0, mac=48'h0123456789AB, payload_words=0, ready=1 → 32'h01234567, 32'h89AB0000 (last), done one cycle later.
- offset=1 / 2 → {00012345, 6789AB00} / {00000123, 456789AB}. offset=3 → 00000001, 23456789, AB000000.
- offset=0, payload_words=2, seed=32'hFFFFFFFF → header words, then FFFFFFFF, 00000000 (last). Checks wrap.
- ready toggled 1,0,0,1 across the frame → data_out/last held during stalls, no word dropped or duplicated, total 4 transfers.
- start pulsed again mid-frame and mac_in changed while busy → single frame emitted with the originally captured MAC.
- clear asserted on the 2nd payload word of a 5-word frame → data_valid=0 next cycle, no done pulse, a new start produces a fresh frame from header word 0.

Source files
------------

// File: rtl/mac_gen_pkg.sv
// Shared types and constants for the MAC frame generator.
// The header is the MAC placed in a 12-byte window after 0..3 pad bytes.
package mac_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    DONE = 2'd3
  } gen_state_t;

  localparam int HDR_WORDS_MAX = 3;
  localparam int WORD_BYTES    = 4;
  localparam int MAC_BYTES     = 6;
  localparam int HDR_BYTES     = HDR_WORDS_MAX * WORD_BYTES;

  // Byte k of the MAC in wire order (k=0 is mac[47:40]).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input int k);
    return mac[47-8*k -: 8];
  endfunction

endpackage

// File: rtl/mac_header_packer.sv
// Combinational header builder: pad bytes, six MAC bytes, then pad to a word boundary.
// Word 0 is hdr_words_o[0]; byte 0 of each word sits in bits [31:24].
module mac_header_packer
  import mac_gen_pkg::*;
#(
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic [47:0]                    mac_i,
  input  logic [1:0]                     byte_offset_i,
  output logic [HDR_WORDS_MAX-1:0][31:0] hdr_words_o,
  output logic [1:0]                     hdr_count_o
);

  logic [7:0] lane;

  always_comb begin
    hdr_words_o = '0;
    lane        = FILL_BYTE;
    for (int b = 0; b < HDR_BYTES; b++) begin
      lane = FILL_BYTE;
      if (b >= int'(byte_offset_i) && b < int'(byte_offset_i) + MAC_BYTES) begin
        lane = mac_byte(mac_i, b - int'(byte_offset_i));
      end
      hdr_words_o[b/WORD_BYTES][31-8*(b%WORD_BYTES) -: 8] = lane;
    end
  end

  // Offset 3 pushes the last MAC byte into a third word.
  assign hdr_count_o = (byte_offset_i == 2'd3) ? 2'd3 : 2'd2;

endmodule

// File: rtl/mac_frame_generator.sv
// Replay transmitter: emits header words carrying a MAC at a byte offset,
// followed by a counting payload, over a valid/ready stream.
module mac_frame_generator
  import mac_gen_pkg::*;
#(
  parameter int         PAYLOAD_W = 9,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 start,
  input  logic [47:0]          mac_in,
  input  logic [1:0]           byte_offset,
  input  logic [PAYLOAD_W-1:0] payload_words,
  input  logic [31:0]          seed,
  input  logic                 ready,
  output logic [31:0]          data_out,
  output logic                 data_valid,
  output logic                 last,
  output logic                 busy,
  output logic                 done,
  output gen_state_t           dbg_state_o
);

  // Handshake: a word moves on any cycle with data_valid & ready. Outputs are
  // decoded from registered state only, so while data_valid & !ready they hold
  // and valid never drops without a transfer (clear/rst excepted).

  gen_state_t                        state_q, state_d;
  logic [47:0]                       mac_q;
  logic [1:0]                        off_q;
  logic [PAYLOAD_W-1:0]              pw_q;
  logic [31:0]                       seed_q;
  logic [1:0]                        hdr_idx_q, hdr_idx_d;
  logic [PAYLOAD_W-1:0]              pay_cnt_q, pay_cnt_d;
  logic [HDR_WORDS_MAX-1:0][31:0]    hdr_words;
  logic [1:0]                        hdr_count;
  logic                              xfer;
  logic                              hdr_last;
  logic                              pay_last;
  logic                              capture;

  mac_header_packer #(
    .FILL_BYTE(FILL_BYTE)
  ) u_packer (
    .mac_i        (mac_q),
    .byte_offset_i(off_q),
    .hdr_words_o  (hdr_words),
    .hdr_count_o  (hdr_count)
  );

  assign xfer     = data_valid & ready;
  assign hdr_last = (hdr_idx_q == hdr_count - 2'd1);
  assign pay_last = (pay_cnt_q == pw_q - {{(PAYLOAD_W-1){1'b0}}, 1'b1});
  assign capture  = (state_q == IDLE) && start && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = HDR;
      HDR:  if (xfer && hdr_last) state_d = (pw_q == '0) ? DONE : PAY;
      PAY:  if (xfer && pay_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_comb begin
    data_out   = '0;
    data_valid = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      HDR: begin
        data_valid = 1'b1;
        busy       = 1'b1;
        data_out   = hdr_words[hdr_idx_q];
        last       = hdr_last && (pw_q == '0);
      end
      PAY: begin
        data_valid = 1'b1;
        busy       = 1'b1;
        data_out   = seed_q + 32'(pay_cnt_q);
        last       = pay_last;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

  always_comb begin
    hdr_idx_d = hdr_idx_q;
    pay_cnt_d = pay_cnt_q;
    if (clear || state_q == IDLE) begin
      hdr_idx_d = '0;
      pay_cnt_d = '0;
    end else if (xfer) begin
      if (state_q == HDR && !hdr_last) hdr_idx_d = hdr_idx_q + 2'd1;
      if (state_q == PAY)              pay_cnt_d = pay_cnt_q + {{(PAYLOAD_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_q     <= '0;
      off_q     <= '0;
      pw_q      <= '0;
      seed_q    <= '0;
      hdr_idx_q <= '0;
      pay_cnt_q <= '0;
    end else begin
      hdr_idx_q <= hdr_idx_d;
      pay_cnt_q <= pay_cnt_d;
      if (capture) begin
        mac_q  <= mac_in;
        off_q  <= byte_offset;
        pw_q   <= payload_words;
        seed_q <= seed;
      end
    end
  end

endmodule

// File: tb/tb_mac_frame_generator.sv
// Bench for mac_frame_generator: a word-queue frame model checked every cycle,
// directed test-plan frames with literal expectations, then randomized frames.
module tb_mac_frame_generator;
  import mac_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clear, start, ready;
  logic [47:0] mac_in;
  logic [1:0]  byte_offset;
  logic [8:0]  payload_words;
  logic [31:0] seed;
  logic [31:0] data_out;
  logic        data_valid, last, busy, done;
  gen_state_t  dbg_state;

  mac_frame_generator #(.PAYLOAD_W(9), .FILL_BYTE(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .start        (start),
    .mac_in       (mac_in),
    .byte_offset  (byte_offset),
    .payload_words(payload_words),
    .seed         (seed),
    .ready        (ready),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .last         (last),
    .busy         (busy),
    .done         (done),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  localparam logic [47:0] M = 48'h0123456789AB;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic        exp_done = 1'b0;
  logic        chk_en = 1'b0;
  logic [31:0] obs_q[$];
  int          done_cnt = 0;
  logic [31:0] lit_tab [4][3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- model: byte stream of pad + MAC + pad, then seed + i ----
  function automatic int hdr_words_of(input int off);
    return (off + 6 + 3) / 4;
  endfunction

  function automatic logic [31:0] model_word(input logic [47:0] mac, input int off,
                                             input logic [31:0] sd, input int i);
    logic [31:0] w;
    logic [7:0]  by;
    int          hw, p;
    hw = hdr_words_of(off);
    w  = '0;
    if (i < hw) begin
      for (int b = 0; b < 4; b++) begin
        p  = 4 * i + b;
        by = (p >= off && p < off + 6) ? 8'(mac >> (8 * (5 - (p - off)))) : 8'h00;
        w  = {w[23:0], by};
      end
    end else begin
      w = sd + 32'(i - hw);
    end
    return w;
  endfunction

  function automatic void load_frame(input logic [47:0] mac, input int off,
                                     input int pw, input logic [31:0] sd);
    for (int i = 0; i < hdr_words_of(off) + pw; i++) exp_q.push_back(model_word(mac, off, sd, i));
  endfunction

  // ---- per-cycle compare and model advance ----
  always @(negedge clk) begin
    logic was_idle;
    logic nd;
    if (chk_en && !rst) begin
      check("valid", 32'(data_valid), 32'(exp_q.size() > 0));
      check("busy", 32'(busy), 32'(exp_q.size() > 0));
      check("done", 32'(done), 32'(exp_done));
      if (exp_q.size() > 0) begin
        check("data", data_out, exp_q[0]);
        check("last", 32'(last), 32'(exp_q.size() == 1));
      end
      if (done) done_cnt++;
      was_idle = (exp_q.size() == 0) && !exp_done;
      nd = 1'b0;
      if (clear) begin
        exp_q.delete();
      end else if (exp_q.size() > 0 && ready) begin
        obs_q.push_back(data_out);
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) nd = 1'b1;
      end else if (was_idle && start) begin
        load_frame(mac_in, int'(byte_offset), int'(payload_words), seed);
      end
      exp_done = nd;
    end
  end

  // ---- driver tasks ----
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] mac, input logic [1:0] off,
                      input logic [8:0] pw, input logic [31:0] sd);
    mac_in = mac; byte_offset = off; payload_words = pw; seed = sd;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  function automatic logic model_idle();
    return (exp_q.size() == 0) && !exp_done && !busy && !done && !data_valid;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!model_idle() && n < budget) begin
      cyc();
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL timeout: frame still active after %0d cycles", budget);
    end
  endtask

  task automatic check_obs(input string name, input int idx, input logic [31:0] exp);
    if (idx < obs_q.size()) check(name, obs_q[idx], exp);
    else check(name, 32'hDEADBEEF, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    lit_tab[0] = '{32'h01234567, 32'h89AB0000, 32'h0};
    lit_tab[1] = '{32'h00012345, 32'h6789AB00, 32'h0};
    lit_tab[2] = '{32'h00000123, 32'h456789AB, 32'h0};
    lit_tab[3] = '{32'h00000001, 32'h23456789, 32'hAB000000};

    rst = 1'b1; clear = 1'b0; start = 1'b0; ready = 1'b1;
    mac_in = '0; byte_offset = '0; payload_words = '0; seed = '0;
    #2;
    check("rst_data", data_out, 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_last", 32'(last), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);

    // pin the model against hand-computed words
    for (int off = 0; off < 4; off++)
      for (int i = 0; i < hdr_words_of(off); i++)
        check("pin_hdr", model_word(M, off, 32'h0, i), lit_tab[off][i]);
    check("pin_wrap0", model_word(M, 0, 32'hFFFFFFFF, 2), 32'hFFFFFFFF);
    check("pin_wrap1", model_word(M, 0, 32'hFFFFFFFF, 3), 32'h00000000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    cyc();

    // header-only frames at every offset
    for (int off = 0; off < 4; off++) begin
      obs_q.delete();
      d0 = done_cnt;
      send(M, 2'(off), 9'd0, 32'h0);
      wait_idle(50);
      check("hdr_count", 32'(obs_q.size()), 32'(off == 3 ? 3 : 2));
      for (int i = 0; i < (off == 3 ? 3 : 2); i++) check_obs("hdr_word", i, lit_tab[off][i]);
      check("hdr_done_cnt", 32'(done_cnt - d0), 32'd1);
    end

    // payload wrap, ready high
    obs_q.delete();
    send(M, 2'd0, 9'd2, 32'hFFFFFFFF);
    wait_idle(50);
    check("wrap_len", 32'(obs_q.size()), 32'd4);
    check_obs("wrap_w2", 2, 32'hFFFFFFFF);
    check_obs("wrap_w3", 3, 32'h00000000);

    // stalls: ready pattern 1,0,0,1,...
    obs_q.delete();
    send(M, 2'd0, 9'd2, 32'hFFFFFFFF);
    begin
      logic pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 8 && !model_idle(); k++) begin
        ready = pat[k];
        cyc();
      end
    end
    ready = 1'b1;
    wait_idle(50);
    check("stall_len", 32'(obs_q.size()), 32'd4);
    check_obs("stall_w0", 0, 32'h01234567);
    check_obs("stall_w1", 1, 32'h89AB0000);
    check_obs("stall_w3", 3, 32'h00000000);

    // restart and MAC change while busy are ignored
    obs_q.delete();
    d0 = done_cnt;
    send(M, 2'd1, 9'd3, 32'h100);
    mac_in = 48'hFFFFFFFFFFFF; byte_offset = 2'd3; seed = 32'h5555; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_idle(50);
    check("busy_len", 32'(obs_q.size()), 32'd5);
    check_obs("busy_w0", 0, 32'h00012345);
    check_obs("busy_w1", 1, 32'h6789AB00);
    check_obs("busy_w4", 4, 32'h00000102);
    check("busy_done_cnt", 32'(done_cnt - d0), 32'd1);

    // clear on the 2nd payload word of a 5-word frame
    obs_q.delete();
    d0 = done_cnt;
    send(M, 2'd0, 9'd5, 32'h10);
    for (int n = 0; n < 20 && obs_q.size() < 3; n++) cyc();
    check("clr_at_pay1", data_out, 32'h11);
    ready = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    ready = 1'b1;
    check("clr_valid", 32'(data_valid), 32'h0);
    check("clr_busy", 32'(busy), 32'h0);
    cyc();
    check("clr_done_cnt", 32'(done_cnt - d0), 32'd0);
    obs_q.delete();
    send(M, 2'd2, 9'd1, 32'h7);
    wait_idle(50);
    check("clr_new_len", 32'(obs_q.size()), 32'd3);
    check_obs("clr_new_w0", 0, 32'h00000123);
    check_obs("clr_new_w2", 2, 32'h00000007);

    // randomized frames with random backpressure, stray starts and clears
    for (int f = 0; f < 40; f++) begin
      send({16'($urandom), $urandom}, 2'($urandom_range(0, 3)),
           9'($urandom_range(0, 6)), $urandom);
      for (int n = 0; n < 300; n++) begin
        if (model_idle()) break;
        ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 9) == 0);
        clear = ($urandom_range(0, 59) == 0);
        mac_in = {16'($urandom), $urandom};
        byte_offset = 2'($urandom_range(0, 3));
        payload_words = 9'($urandom_range(0, 6));
        seed = $urandom;
        cyc();
      end
      start = 1'b0; clear = 1'b0; ready = 1'b1;
      wait_idle(50);
    end

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
